// File: rtl/pc_fetch_pkg.sv
// Shared types for the fetch sequencer: FSM states, redirect source encoding, default vectors.
// Pure declarations, no latency or flow control of its own.
package pc_fetch_pkg;

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  typedef enum logic [1:0] {RD_NONE, RD_BR, RD_JMP, RD_EXC} rd_src_t;

  localparam logic [15:0] EXC_VEC_DEFAULT = 16'h0040;

endpackage

// File: rtl/redirect_arb.sv
// Fixed-priority redirect select (exc > jmp > br) into {vld, src, tgt}; purely combinational.
// No backpressure: the result is consumed in the same cycle by the fetch FSM.
module redirect_arb
  import pc_fetch_pkg::*;
#(
  parameter int SIZE = 16
) (
  input  logic            exc,
  input  logic [SIZE-1:0] exc_tgt,
  input  logic            jmp,
  input  logic [SIZE-1:0] jmp_tgt,
  input  logic            br,
  input  logic [SIZE-1:0] br_tgt,
  output logic            vld,
  output rd_src_t         src,
  output logic [SIZE-1:0] tgt
);

  always_comb begin
    vld = exc | jmp | br;
    src = RD_NONE;
    tgt = br_tgt;
    if (exc) begin
      src = RD_EXC;
      tgt = exc_tgt;
    end else if (jmp) begin
      src = RD_JMP;
      tgt = jmp_tgt;
    end else if (br) begin
      src = RD_BR;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives PC load/increment, imem request, one-entry instr slot; 1 instr/cycle at single-cycle ack.
// Backpressure: slot stall parks the FSM in HOLD with no request; optional PC_FETCH_PERF_EN adds perf counters.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int              SIZE      = 16,
  parameter int              IW        = 32,
  parameter logic [SIZE-1:0] RESET_VEC = '0,
  parameter logic [SIZE-1:0] EXC_VEC   = SIZE'(EXC_VEC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] pc_q,
  output logic            pc_en,
  output logic            pc_aload,
  output logic [SIZE-1:0] pc_d,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [IW-1:0]   imem_rdata,
  output logic [IW-1:0]   instr,
  output logic [SIZE-1:0] instr_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
`ifdef PC_FETCH_PERF_EN
  output logic [15:0]     perf_fetch,
  output logic [15:0]     perf_flush,
`endif
  input  logic            exc,
  input  logic            jmp,
  input  logic [SIZE-1:0] jmp_target,
  input  logic            br_taken,
  input  logic [SIZE-1:0] br_target
);

  state_t          state, state_nxt;
  logic            pend_v, pend_v_nxt;
  rd_src_t         pend_src, pend_src_nxt;
  logic [SIZE-1:0] pend_tgt, pend_tgt_nxt;
  logic            vld_nxt, cap;

  logic            live_vld, rd_vld;
  rd_src_t         live_src, rd_src;
  logic [SIZE-1:0] live_tgt, rd_tgt;
  logic            pend_is_exc;

  assign pend_is_exc = pend_v && (pend_src == RD_EXC);

  redirect_arb #(.SIZE(SIZE)) u_live (
    .exc(exc), .exc_tgt(EXC_VEC), .jmp(jmp), .jmp_tgt(jmp_target),
    .br(br_taken), .br_tgt(br_target), .vld(live_vld), .src(live_src), .tgt(live_tgt)
  );

  // Merge live with latched: a latched exc survives later jmp/br, otherwise the newest redirect wins.
  redirect_arb #(.SIZE(SIZE)) u_merge (
    .exc(exc | pend_is_exc), .exc_tgt(EXC_VEC), .jmp(live_vld), .jmp_tgt(live_tgt),
    .br(pend_v), .br_tgt(pend_tgt), .vld(rd_vld), .src(rd_src), .tgt(rd_tgt)
  );

  always_comb begin
    state_nxt    = state;
    pend_v_nxt   = pend_v;
    pend_src_nxt = pend_src;
    pend_tgt_nxt = pend_tgt;
    vld_nxt      = instr_valid && !instr_ready;
    cap          = 1'b0;
    imem_req     = 1'b0;
    pc_en        = 1'b0;
    pc_aload     = 1'b0;
    pc_d         = rd_tgt;
    unique case (state)
      BOOT: begin
        pc_aload  = 1'b1;
        pc_d      = RESET_VEC;
        state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack && rd_vld) begin
          pc_aload   = 1'b1;
          pend_v_nxt = 1'b0;
          vld_nxt    = 1'b0;
        end else if (imem_ack && (!instr_valid || instr_ready)) begin
          cap     = 1'b1;
          pc_en   = 1'b1;
          vld_nxt = 1'b1;
          if (!instr_ready) state_nxt = HOLD;
        end else if (imem_ack) begin
          // Slot blocked: word dropped, PC not advanced, so the resume refetches it.
          state_nxt = HOLD;
        end else if (live_vld) begin
          pend_v_nxt   = 1'b1;
          pend_src_nxt = (rd_src == RD_EXC) ? RD_EXC : live_src;
          pend_tgt_nxt = rd_tgt;
          vld_nxt      = 1'b0;
        end
      end
      HOLD: begin
        if (live_vld) begin
          pc_aload  = 1'b1;
          vld_nxt   = 1'b0;
          state_nxt = FETCH;
        end else if (instr_ready) begin
          vld_nxt   = 1'b0;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase
    if (!rst) begin
      imem_req = 1'b0;
      pc_en    = 1'b0;
      pc_aload = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      pend_v      <= 1'b0;
      pend_src    <= RD_NONE;
      pend_tgt    <= '0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      state       <= state_nxt;
      pend_v      <= pend_v_nxt;
      pend_src    <= pend_src_nxt;
      pend_tgt    <= pend_tgt_nxt;
      instr_valid <= vld_nxt;
      if (cap) begin
        instr    <= imem_rdata;
        instr_pc <= pc_q;
      end
    end
  end

`ifdef PC_FETCH_PERF_EN
  logic flush_app;
  assign flush_app = pc_aload && (state != BOOT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch <= '0;
      perf_flush <= '0;
    end else begin
      if (instr_valid && instr_ready && perf_fetch != 16'hFFFF) perf_fetch <= perf_fetch + 16'd1;
      if (flush_app && perf_flush != 16'hFFFF) perf_flush <= perf_flush + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: external PC counter, imem responder, address-level reference model and scoreboard.
// Directed scenarios first, then randomized acks, stalls and redirects with one mid-run reset.
module tb_pc_fetch_ctrl;

  localparam logic [15:0] RVEC = 16'h0010;
  localparam logic [15:0] EVEC = 16'h0040;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_q, pc_d, instr_pc, jmp_target, br_target;
  logic        pc_en, pc_aload, imem_req, imem_ack, instr_valid, instr_ready;
  logic        exc, jmp, br_taken;
  logic [31:0] imem_rdata, instr;
`ifdef PC_FETCH_PERF_EN
  logic [15:0] perf_fetch, perf_flush;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // Reference model state: next address decode should see, and pending-redirect bookkeeping.
  logic [15:0] exp_next = RVEC;
  bit          pend_x = 0, pend_any = 0, boot_nxt = 1;
  int          n_del = 0, n_red = 0, tot_del = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.SIZE(16), .IW(32), .RESET_VEC(RVEC), .EXC_VEC(EVEC)) dut (
    .clk(clk), .rst(rst), .pc_q(pc_q), .pc_en(pc_en), .pc_aload(pc_aload), .pc_d(pc_d),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
`ifdef PC_FETCH_PERF_EN
    .perf_fetch(perf_fetch), .perf_flush(perf_flush),
`endif
    .exc(exc), .jmp(jmp), .jmp_target(jmp_target), .br_taken(br_taken), .br_target(br_target)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          pc_q <= '0;
    else if (pc_aload) pc_q <= pc_d;
    else if (pc_en)    pc_q <= pc_q + 16'd1;
  end

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'hA5C3, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    if (!rst) begin
      exp_next = RVEC; pend_x = 0; pend_any = 0; boot_nxt = 1; n_del = 0; n_red = 0;
    end else if (boot_nxt) begin
      chk("boot_aload", pc_aload, 1);
      chk("boot_pc_d", pc_d, RVEC);
      chk("boot_req", imem_req, 0);
      boot_nxt = 0;
    end else begin
      chk("en_aload_excl", pc_en & pc_aload, 0);
      if (instr_valid && instr_ready) begin
        exp_q.push_back(exp_next);
        exp_next = exp_next + 16'd1;
        n_del++; tot_del++;
      end
      if ((exc || jmp || br_taken) && !(pend_x && !exc)) begin
        exp_next = exc ? EVEC : (jmp ? jmp_target : br_target);
        pend_x   = exc;
        pend_any = 1;
      end
      if (imem_req && !imem_ack) chk("pc_hold_unacked", {pc_en, pc_aload}, 0);
      else if (pend_any) begin
        n_red++; pend_any = 0; pend_x = 0;
      end
    end
  endtask

  task automatic cycle(input bit r, input bit e, input bit j, input logic [15:0] jt,
                       input bit b, input logic [15:0] bt, input bit a, input bit rdy);
    @(negedge clk);
    #1;
    rst = r; exc = e; jmp = j; jmp_target = jt; br_taken = b; br_target = bt;
    instr_ready = rdy;
    imem_ack = a && r && imem_req;
    imem_rdata = imem_ack ? mem_word(pc_q) : $urandom;
    #1;
    model_step();
  endtask

  // Scoreboard monitor: pops the expected address on every accepted delivery.
  initial begin
    logic [15:0] p;
    forever begin
      @(negedge clk);
      #3;
      if (rst && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_delivery: got pc %h, expected no delivery", instr_pc);
        end else begin
          p = exp_q.pop_front();
          chk("instr_pc", instr_pc, p);
          chk("instr", instr, mem_word(p));
        end
      end
    end
  end

  initial begin
    exc = 0; jmp = 0; br_taken = 0; jmp_target = 0; br_target = 0;
    instr_ready = 0; imem_ack = 0; imem_rdata = 0;

    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_en", pc_en, 0);
    chk("rst_aload", pc_aload, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);

    // Boot, then back-to-back delivery from RESET_VEC.
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 0, 0, 0, 1, 1);
      chk("stream_valid", instr_valid, 1);
      chk("stream_pc", instr_pc, RVEC + 16'(i));
    end

    // Delayed ack at 0x0005.
    cycle(1, 0, 1, 16'h0005, 0, 0, 1, 1);
    repeat (3) begin
      cycle(1, 0, 0, 0, 0, 0, 0, 1);
      chk("wait_req", imem_req, 1);
      chk("wait_pc_stable", pc_q, 16'h0005);
      chk("wait_no_en", pc_en, 0);
    end
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    chk("ack_en", pc_en, 1);

    // Jump latched two cycles before a delayed ack.
    cycle(1, 0, 1, 16'h0100, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    chk("pend_aload", pc_aload, 1);
    chk("pend_pc_d", pc_d, 16'h0100);
    chk("pend_no_en", pc_en, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
    chk("pend_pc_q", pc_q, 16'h0100);
    chk("pend_flushed", instr_valid, 0);

    // All three redirects at once.
    cycle(1, 1, 1, 16'h0200, 1, 16'h0300, 1, 1);
    chk("prio_pc_d", pc_d, EVEC);
    chk("prio_aload", pc_aload, 1);

    // Stall decode after delivering 0x0020.
    cycle(1, 0, 1, 16'h0020, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) begin
      cycle(1, 0, 0, 0, 0, 0, 1, 0);
      chk("hold_req", imem_req, 0);
      chk("hold_valid", instr_valid, 1);
      chk("hold_pc", instr_pc, 16'h0020);
      chk("hold_instr", instr, mem_word(16'h0020));
    end
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    chk("resume_req", imem_req, 1);
    chk("resume_pc", pc_q, 16'h0021);

    // Randomized traffic with a mid-run reset.
    for (int i = 0; i < 4000; i++) begin
      bit r;
      r = !(i >= 2000 && i < 2003);
      cycle(r, $urandom % 24 == 0, $urandom % 12 == 0, 16'($urandom), $urandom % 10 == 0,
            16'($urandom), $urandom % 3 != 0, $urandom % 4 != 0);
      if (!r) begin
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_valid", instr_valid, 0);
      end
    end

    cycle(1, 0, 0, 0, 0, 0, 0, 0);
`ifdef PC_FETCH_PERF_EN
    chk("perf_fetch", perf_fetch, n_del);
    chk("perf_flush", perf_flush, n_red);
`endif
    #2;
    chk("progress", tot_del > 200, 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
